// File: rtl/cpu_control_seq.sv
// Hardwired Moore control sequencer: steps the single-bus datapath through fetch, decode and execute.
// Controls decode from the state register (plus IR opcode), so clr silences every strobe at once.
module cpu_control_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OP_W        = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal,
  output logic        mem_fault
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_ADDI, C_MUL, C_LD, C_ST, C_NOP, C_HALT, C_ILL
  } cls_t;

  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(30);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(31);

  state_t          state_q, state_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            illegal_q, illegal_d;
  logic            mem_fault_q, mem_fault_d;
  logic [OP_W-1:0] opcode;
  cls_t            cls;
  logic            boundary;
  logic            mem_wait;
  logic            unused_ir;

  assign opcode    = ir[31 -: OP_W];
  // Register fields and immediates are consumed by the datapath, not by the sequencer.
  assign unused_ir = ^ir[31-OP_W:0];
  assign illegal   = illegal_q;
  assign mem_fault = mem_fault_q;

  always_comb begin
    cls = C_ILL;
    if (opcode <= OP_OR)         cls = C_ALU;
    else if (opcode == OP_ADDI)  cls = C_ADDI;
    else if (opcode == OP_MUL)   cls = C_MUL;
    else if (opcode == OP_LD)    cls = C_LD;
    else if (opcode == OP_ST)    cls = C_ST;
    else if (opcode == OP_NOP)   cls = C_NOP;
    else if (opcode == OP_HALT)  cls = C_HALT;
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    illegal_d   = illegal_q;
    mem_fault_d = mem_fault_q;
    boundary    = 1'b0;
    mem_wait    = 1'b0;
    case (state_q)
      S_RST:   boundary = 1'b1;
      S_T0:    state_d = S_T1;
      S_T1: begin
        mem_wait = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2:    state_d = S_T3;
      S_T3: begin
        case (cls)
          C_NOP:  boundary = 1'b1;
          C_HALT: state_d = S_HALT;
          C_ILL: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default: state_d = S_T4;
        endcase
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
        if (cls == C_ALU || cls == C_ADDI) boundary = 1'b1;
        else                               state_d = S_T6;
      end
      S_T6: begin
        if (cls == C_LD) begin
          mem_wait = 1'b1;
          if (mem_ready) state_d = S_T7;
        end else if (cls == C_ST) begin
          state_d = S_T7;
        end else begin
          boundary = 1'b1;
        end
      end
      S_T7: begin
        if (cls == C_ST) begin
          mem_wait = 1'b1;
          if (mem_ready) boundary = 1'b1;
        end else begin
          boundary = 1'b1;
        end
      end
      S_PAUSE: boundary = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    // Every return to T0 passes through here, which is where a pause request is honoured.
    if (boundary) state_d = stop ? S_PAUSE : S_T0;
    if (mem_wait && !mem_ready) begin
      if (wait_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
        state_d     = S_HALT;
        mem_fault_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= S_RST;
      wait_cnt_q  <= '0;
      illegal_q   <= 1'b0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      illegal_q   <= illegal_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // T3 controls depend on the opcode that only lands in IR at the end of T2.
  always_comb begin
    {PCout, Zlowout, Zhighout, MDRout, Cout, BAout}        = '0;
    {PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin} = '0;
    {Gra, Grb, Grc, Rin, Rout, Read, Write}                 = '0;
    alu_op = '0;
    run    = 1'b0;
    case (state_q)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        case (cls)
          C_ALU, C_ADDI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_MUL:         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LD, C_ST:    begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        run = 1'b1;
        case (cls)
          C_ALU:   begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = 5'(opcode); end
          C_MUL:   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = 5'(opcode); end
          C_ADDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        run = 1'b1;
        case (cls)
          C_ALU, C_ADDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MUL:         begin Zlowout = 1'b1; LOin = 1'b1; end
          C_LD, C_ST:    begin Zlowout = 1'b1; MARin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        run = 1'b1;
        case (cls)
          C_MUL: begin Zhighout = 1'b1; HIin = 1'b1; end
          C_LD:  begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        run = 1'b1;
        case (cls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_seq.sv
// Randomised bench for cpu_control_seq: each instruction is expanded from its micro-step table
// into per-cycle expected control words, then replayed against the sequencer.
module tb_cpu_control_seq;

  localparam int TMO = 4;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_ADDI = 5'd4, OP_MUL = 5'd5;
  localparam logic [4:0] OP_LD = 5'd6, OP_ST = 5'd7, OP_NOP = 5'd30, OP_HALT = 5'd31;

  localparam logic [29:0] PCO  = 30'd1 << 0,  ZLO  = 30'd1 << 1,  ZHI  = 30'd1 << 2;
  localparam logic [29:0] MDRO = 30'd1 << 3,  CO   = 30'd1 << 4,  BAO  = 30'd1 << 5;
  localparam logic [29:0] PCI  = 30'd1 << 6,  INCPC = 30'd1 << 7, MARI = 30'd1 << 8;
  localparam logic [29:0] MDRI = 30'd1 << 9,  IRI  = 30'd1 << 10, YIN  = 30'd1 << 11;
  localparam logic [29:0] ZIN  = 30'd1 << 12, HII  = 30'd1 << 13, LOI  = 30'd1 << 14;
  localparam logic [29:0] GRA  = 30'd1 << 15, GRB  = 30'd1 << 16, GRC  = 30'd1 << 17;
  localparam logic [29:0] RIN  = 30'd1 << 18, ROUT = 30'd1 << 19, RD   = 30'd1 << 20;
  localparam logic [29:0] WR   = 30'd1 << 21, RUN  = 30'd1 << 22;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  logic        stop = 1'b0;
  logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
  logic PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, Read, Write;
  logic [4:0] alu_op;
  logic run, illegal, mem_fault;
  logic [29:0] obs;

  int n_run  = 0;
  int n_fail = 0;
  bit hlt;

  typedef struct packed {
    logic        clr_n;
    logic        rdy;
    logic        stp;
    logic [31:0] ir;
    logic [29:0] exp;
  } cyc_t;

  cyc_t plan[$];
  logic ill_m = 1'b0;
  logic flt_m = 1'b0;

  always #5 clk = ~clk;

  cpu_control_seq #(.MEM_TIMEOUT(TMO), .OP_W(5)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Cout(Cout), .BAout(BAout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Read(Read),
    .Write(Write), .alu_op(alu_op), .run(run), .illegal(illegal), .mem_fault(mem_fault)
  );

  assign obs = {mem_fault, illegal, alu_op, run, Write, Read, Rout, Rin, Grc, Grb, Gra,
                LOin, HIin, Zin, Yin, IRin, MDRin, MARin, IncPC, PCin, BAout, Cout,
                MDRout, Zhighout, Zlowout, PCout};

  function automatic logic [29:0] flags();
    return {flt_m, ill_m, 28'b0};
  endfunction

  function automatic logic [29:0] alu(input logic [4:0] op);
    return {2'b00, op, 23'b0};
  endfunction

  function automatic int nsteps(input logic [4:0] op);
    if (op <= OP_ADDI) return 6;
    if (op == OP_MUL) return 7;
    if (op == OP_LD || op == OP_ST) return 8;
    return 4;
  endfunction

  // Micro-step table: control word asserted in step s of instruction op.
  function automatic logic [29:0] micro(input logic [4:0] op, input int s);
    logic [29:0] r;
    r = RUN;
    if (s == 0)      r |= PCO | MARI | INCPC | ZIN;
    else if (s == 1) r |= ZLO | PCI | RD | MDRI;
    else if (s == 2) r |= MDRO | IRI;
    else if (op <= OP_ADDI) begin
      if (s == 3) r |= GRB | ROUT | YIN;
      if (s == 4) r |= (op == OP_ADDI) ? (CO | ZIN) : (GRC | ROUT | ZIN | alu(op));
      if (s == 5) r |= ZLO | GRA | RIN;
    end else if (op == OP_MUL) begin
      if (s == 3) r |= GRA | ROUT | YIN;
      if (s == 4) r |= GRB | ROUT | ZIN | alu(5'd5);
      if (s == 5) r |= ZLO | LOI;
      if (s == 6) r |= ZHI | HII;
    end else if (op == OP_LD || op == OP_ST) begin
      if (s == 3) r |= GRB | BAO | YIN;
      if (s == 4) r |= CO | ZIN;
      if (s == 5) r |= ZLO | MARI;
      if (s == 6) r |= (op == OP_LD) ? (RD | MDRI) : (GRA | ROUT | MDRI);
      if (s == 7) r |= (op == OP_LD) ? (MDRO | GRA | RIN) : WR;
    end
    return r;
  endfunction

  task automatic push(input bit c, input bit rdy, input bit stp, input logic [31:0] irv,
                      input logic [29:0] e);
    cyc_t x;
    x.clr_n = c; x.rdy = rdy; x.stp = stp; x.ir = irv; x.exp = e;
    plan.push_back(x);
  endtask

  // wf/wm: cycles memory stays not-ready in the fetch / data access; stp: stop at the boundary.
  task automatic plan_instr(input logic [4:0] op, input int wf, input int wm, input bit stp,
                            input int np, output bit halted);
    logic [31:0] irv;
    int n;
    int w;
    bit last;
    bit wt;
    irv = {op, 27'($urandom)};
    n = nsteps(op);
    halted = 1'b0;
    for (int s = 0; s < n; s++) begin
      wt = (s == 1) || (s == 6 && op == OP_LD) || (s == 7 && op == OP_ST);
      w = !wt ? 0 : (s == 1) ? wf : wm;
      for (int k = 0; k <= w && k < TMO; k++) begin
        last = (s == n - 1) && (k == w);
        push(1'b1, wt ? (k == w) : 1'($urandom), last ? stp : 1'($urandom), irv,
             micro(op, s) | flags());
      end
      if (w >= TMO) begin
        flt_m = 1'b1;
        halted = 1'b1;
        return;
      end
    end
    if (op == OP_HALT) begin
      halted = 1'b1;
    end else if (n == 4 && op != OP_NOP) begin
      ill_m = 1'b1;
      halted = 1'b1;
    end else if (stp) begin
      for (int k = 0; k < np; k++) push(1'b1, 1'($urandom), 1'b1, irv, flags());
      push(1'b1, 1'($urandom), 1'b0, irv, flags());
    end
  endtask

  task automatic push_halt(input int n);
    for (int k = 0; k < n; k++) push(1'b1, 1'($urandom), 1'($urandom), $urandom, flags());
  endtask

  task automatic push_reset(input int n);
    ill_m = 1'b0;
    flt_m = 1'b0;
    for (int k = 0; k < n; k++) push(1'b0, 1'($urandom), 1'($urandom), $urandom, 30'd0);
    push(1'b1, 1'($urandom), 1'b0, $urandom, 30'd0);
  endtask

  task automatic drive_cycle(input cyc_t c, output logic [29:0] got);
    @(negedge clk);
    clr = c.clr_n; mem_ready = c.rdy; stop = c.stp; ir = c.ir;
    #1 got = obs;
  endtask

  task automatic test_reset();
    cyc_t c; logic [29:0] got; int i;
    push_reset(3);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_add();
    cyc_t c; logic [29:0] got; int i;
    plan_instr(OP_ADD, 0, 0, 1'b0, 0, hlt);
    plan_instr(OP_NOP, 0, 0, 1'b0, 0, hlt);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL add_seq cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      if (i == 0) begin
        n_run++;
        if ((got & (PCO | MARI | INCPC | ZIN)) !== (PCO | MARI | INCPC | ZIN)) begin
          n_fail++;
          $display("FAIL add_t0_after_reset got=%h", got);
        end
      end
      if (i == 5) begin
        n_run++;
        if ((got & (GRA | RIN)) !== (GRA | RIN)) begin
          n_fail++;
          $display("FAIL add_t5_writeback got=%h", got);
        end
      end
      i++;
    end
  endtask

  task automatic test_ld_waits();
    cyc_t c; logic [29:0] got; int i; int rd_cnt;
    plan_instr(OP_LD, 3, 2, 1'b0, 0, hlt);
    i = 0; rd_cnt = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      if (got[20]) rd_cnt++;
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL ld_wait cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      i++;
    end
    n_run++;
    if (rd_cnt !== 7) begin
      n_fail++;
      $display("FAIL ld_read_cycles got=%0d exp=7", rd_cnt);
    end
  endtask

  task automatic test_mul();
    cyc_t c; logic [29:0] got; int i;
    plan_instr(OP_MUL, 0, 0, 1'b0, 0, hlt);
    plan_instr(OP_NOP, 0, 0, 1'b0, 0, hlt);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL mul_seq cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      n_run++;
      if (got[1] && got[2]) begin
        n_fail++;
        $display("FAIL mul_bus_conflict cyc%0d got=%h exp=single_source", i, got);
      end
      i++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c; logic [29:0] got; int i;
    plan_instr(5'b01010, 0, 0, 1'b0, 0, hlt);
    push_halt(20);
    push_reset(2);
    plan_instr(OP_NOP, 0, 0, 1'b0, 0, hlt);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL illegal_halt cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_timeout();
    cyc_t c; logic [29:0] got; int i; int wr_cnt;
    plan_instr(OP_ST, 0, TMO, 1'b0, 0, hlt);
    push_halt(5);
    i = 0; wr_cnt = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      if (got[21]) wr_cnt++;
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL st_timeout cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      i++;
    end
    n_run++;
    if (wr_cnt !== TMO) begin
      n_fail++;
      $display("FAIL st_write_cycles got=%0d exp=%0d", wr_cnt, TMO);
    end
  endtask

  task automatic test_stop();
    cyc_t c; logic [29:0] got; int i;
    push_reset(1);
    plan_instr(OP_ADD, 0, 0, 1'b1, 2, hlt);
    c = plan[5];
    c.stp = 1'b1;
    plan[5] = c;
    plan_instr(OP_NOP, 0, 0, 1'b0, 0, hlt);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL stop_pause cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_clr_abort();
    cyc_t c; logic [29:0] got; int i;
    plan_instr(OP_LD, 0, 3, 1'b0, 0, hlt);
    while (plan.size() > 8) void'(plan.pop_back());
    push_reset(1);
    plan_instr(OP_SUB, 0, 0, 1'b0, 0, hlt);
    i = 0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      drive_cycle(c, got);
      n_run++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL clr_abort cyc%0d got=%h exp=%h", i, got, c.exp);
      end
      i++;
    end
  endtask

  task automatic test_random();
    cyc_t c; logic [29:0] got; int i;
    logic [4:0] op;
    logic [4:0] tbl [0:11];
    int wf, wm;
    tbl = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd6, 5'd7, 5'd30, 5'd5};
    i = 0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 29) == 0)      op = OP_HALT;
      else if ($urandom_range(0, 29) == 0) op = 5'($urandom_range(8, 29));
      else                                 op = tbl[$urandom_range(0, 11)];
      wf = ($urandom_range(0, 15) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, TMO - 1);
      wm = ($urandom_range(0, 15) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, TMO - 1);
      plan_instr(op, wf, wm, ($urandom_range(0, 4) == 0), $urandom_range(0, 2), hlt);
      if (hlt) begin
        push_halt($urandom_range(1, 3));
        push_reset($urandom_range(1, 2));
      end
      while (plan.size() > 0) begin
        c = plan.pop_front();
        drive_cycle(c, got);
        n_run++;
        if (got !== c.exp) begin
          n_fail++;
          $display("FAIL random op=%0d cyc%0d got=%h exp=%h", op, i, got, c.exp);
        end
        i++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_waits();
    test_mul();
    test_illegal();
    test_timeout();
    test_stop();
    test_clr_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
